// File: rtl/av_pipe_pkg.sv
// Shared types and constants for the Avalon-MM pipeline stage.
package av_pipe_pkg;

  localparam int AV_DW = 32;
  localparam int AV_AW = 32;

  // Fill pattern returned in place of a read that never came back.
  localparam logic [31:0] AV_DEADBEEF = 32'hDEADBEEF;

  // One buffered command; we=1 marks a write, we=0 a read.
  typedef struct packed {
    logic [AV_AW-1:0]   addr;
    logic [AV_DW/8-1:0] be;
    logic               we;
    logic [AV_DW-1:0]   wdata;
  } av_cmd_t;

  // Width of a counter that must hold values 0 .. n-1.
  function automatic int av_cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/av_cmd_skid.sv
// Two-entry command buffer: MAIN drives the downstream port, SKID catches
// one command while MAIN is stalled. The upstream stall is registered so it
// depends only on flops.
module av_cmd_skid
  import av_pipe_pkg::*;
(
  input  logic    clk_i,
  input  logic    rst_n_i,
  input  logic    in_valid_i,
  input  av_cmd_t in_cmd_i,
  input  logic    ds_wait_i,
  input  logic    pend_full_i,
  output logic    wait_o,
  output logic    out_valid_o,
  output av_cmd_t out_cmd_o
);

  logic    main_valid_q, main_valid_d;
  logic    skid_valid_q, skid_valid_d;
  av_cmd_t main_q, main_d;
  av_cmd_t skid_q, skid_d;
  logic    wait_q, wait_d;
  logic    accept;
  logic    drain;

  // Next-state for MAIN/SKID; SKID is never full while accepting because the
  // registered stall already covers a full SKID.
  always_comb begin
    main_valid_d = main_valid_q;
    main_d       = main_q;
    skid_valid_d = skid_valid_q;
    skid_d       = skid_q;
    accept       = in_valid_i & ~wait_q;
    drain        = main_valid_q & ~ds_wait_i;
    if (drain) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_d = in_cmd_i;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (!main_valid_q) begin
      if (accept) begin
        main_valid_d = 1'b1;
        main_d       = in_cmd_i;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_d       = in_cmd_i;
    end
    wait_d = skid_valid_d | pend_full_i;
  end

  // Buffer and stall registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_q       <= '0;
      skid_q       <= '0;
      wait_q       <= 1'b0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
      wait_q       <= wait_d;
    end
  end

  assign wait_o      = wait_q;
  assign out_valid_o = main_valid_q;
  assign out_cmd_o   = main_q;

endmodule

// File: rtl/av_pipeline_stage.sv
// Registered Avalon-MM pipeline stage with bounded outstanding reads.
// Optional macro AV_PIPE_TIMEOUT_EN: hung reads get a synthetic DEADBEEF
// response and the late real response is discarded.
module av_pipeline_stage
  import av_pipe_pkg::*;
#(
  parameter int DW          = AV_DW,
  parameter int AW          = AV_AW,
  parameter int MAX_PENDING = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_n_i,
  input  logic [AW-1:0]   s_av_address_i,
  input  logic [DW/8-1:0] s_av_byteenable_i,
  input  logic            s_av_read_i,
  input  logic            s_av_write_i,
  input  logic [DW-1:0]   s_av_writedata_i,
  input  logic [7:0]      s_av_burstcount_i,
  output logic            s_av_waitrequest_o,
  output logic [DW-1:0]   s_av_readdata_o,
  output logic            s_av_readdatavalid_o,
  output logic [AW-1:0]   m_av_address_o,
  output logic [DW/8-1:0] m_av_byteenable_o,
  output logic            m_av_read_o,
  output logic            m_av_write_o,
  output logic [DW-1:0]   m_av_writedata_o,
  output logic [7:0]      m_av_burstcount_o,
  input  logic            m_av_waitrequest_i,
  input  logic [DW-1:0]   m_av_readdata_i,
  input  logic            m_av_readdatavalid_i,
  output logic            timeout_o
);

  av_cmd_t       in_cmd, main_cmd;
  logic          main_valid;
  logic          us_rd_acc, ds_rd_acc, pend_full;
  logic [3:0]    pend_q, pend_d, ds_pend_q, ds_pend_d;
  logic          rvalid_q, rvalid_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          unused_burst;

  // Only single-beat transfers exist; the incoming burst count is ignored.
  assign unused_burst = ^s_av_burstcount_i;

  // A write asserted together with a read wins.
  assign in_cmd.addr  = s_av_address_i;
  assign in_cmd.be    = s_av_byteenable_i;
  assign in_cmd.we    = s_av_write_i;
  assign in_cmd.wdata = s_av_writedata_i;

  assign us_rd_acc = s_av_read_i & ~s_av_write_i & ~s_av_waitrequest_o;
  assign ds_rd_acc = m_av_read_o & ~m_av_waitrequest_i;

  // Reads accepted upstream but not yet answered upstream.
  always_comb begin
    pend_d = pend_q + {3'b000, us_rd_acc} - {3'b000, rvalid_q};
  end
  assign pend_full = (pend_d == 4'(MAX_PENDING));

  av_cmd_skid u_skid (
    .clk_i       (wb_clk_i),
    .rst_n_i     (wb_rst_n_i),
    .in_valid_i  (s_av_read_i | s_av_write_i),
    .in_cmd_i    (in_cmd),
    .ds_wait_i   (m_av_waitrequest_i),
    .pend_full_i (pend_full),
    .wait_o      (s_av_waitrequest_o),
    .out_valid_o (main_valid),
    .out_cmd_o   (main_cmd)
  );

  assign m_av_address_o    = main_cmd.addr;
  assign m_av_byteenable_o = main_cmd.be;
  assign m_av_writedata_o  = main_cmd.wdata;
  assign m_av_read_o       = main_valid & ~main_cmd.we;
  assign m_av_write_o      = main_valid & main_cmd.we;
  assign m_av_burstcount_o = 8'h01;

`ifdef AV_PIPE_TIMEOUT_EN
  localparam int CW = av_cnt_width(TIMEOUT_CYC);

  logic [CW-1:0] tcnt_q, tcnt_d;
  logic [3:0]    drop_q, drop_d;
  logic          fire, real_take, real_drop, tmo_q;

  // Response select: real data beats a coinciding timeout; responses owed to
  // already timed-out reads are swallowed via the drop count.
  always_comb begin
    fire      = (ds_pend_q != 4'd0) & ~m_av_readdatavalid_i &
                (tcnt_q == CW'(TIMEOUT_CYC - 1));
    real_drop = m_av_readdatavalid_i & (drop_q != 4'd0);
    real_take = m_av_readdatavalid_i & (drop_q == 4'd0) & (ds_pend_q != 4'd0);
    drop_d    = drop_q + {3'b000, fire} - {3'b000, real_drop};
    tcnt_d    = (m_av_readdatavalid_i | fire | (ds_pend_q == 4'd0)) ? '0 : tcnt_q + CW'(1);
    rvalid_d  = real_take | fire;
    rdata_d   = real_take ? m_av_readdata_i :
                fire      ? {(DW/32){AV_DEADBEEF}} : rdata_q;
    ds_pend_d = ds_pend_q + {3'b000, ds_rd_acc} - {3'b000, rvalid_d};
  end

  // Timeout counter, drop count and the timeout pulse.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      tcnt_q <= '0;
      drop_q <= 4'd0;
      tmo_q  <= 1'b0;
    end else begin
      tcnt_q <= tcnt_d;
      drop_q <= drop_d;
      tmo_q  <= fire;
    end
  end

  assign timeout_o = tmo_q;
`else
  localparam int          unused_cw   = av_cnt_width(TIMEOUT_CYC);
  localparam logic [31:0] unused_fill = AV_DEADBEEF;

  // Response select: a valid with nothing outstanding is stale and dropped.
  always_comb begin
    rvalid_d  = m_av_readdatavalid_i & (ds_pend_q != 4'd0);
    rdata_d   = rvalid_d ? m_av_readdata_i : rdata_q;
    ds_pend_d = ds_pend_q + {3'b000, ds_rd_acc} - {3'b000, rvalid_d};
  end

  assign timeout_o = 1'b0;
`endif

  // Counters and the registered upstream response.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      pend_q    <= 4'd0;
      ds_pend_q <= 4'd0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      pend_q    <= pend_d;
      ds_pend_q <= ds_pend_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
    end
  end

  assign s_av_readdatavalid_o = rvalid_q;
  assign s_av_readdata_o      = rdata_q;

  // Read and write together is an upstream protocol error.
  a_no_rd_wr : assert property (@(posedge wb_clk_i) disable iff (!wb_rst_n_i)
                                !(s_av_read_i && s_av_write_i));

endmodule

// File: tb/tb_av_pipeline_stage.sv
// Randomized and directed bench for av_pipeline_stage with a transaction-level
// reference: command order queue, expected-read queue and a model memory.
module tb_av_pipeline_stage;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXP = 4;
  localparam int TMO  = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [AW-1:0] s_addr = '0;
  logic [3:0]    s_be = '0;
  logic          s_rd = 1'b0, s_wr = 1'b0;
  logic [31:0]   s_wdata = '0;
  logic [7:0]    s_burst = 8'h01;
  logic          s_wait, s_rdv;
  logic [31:0]   s_rdata;
  logic [AW-1:0] m_addr;
  logic [3:0]    m_be;
  logic          m_rd, m_wr;
  logic [31:0]   m_wdata;
  logic [7:0]    m_burst;
  logic          m_wait = 1'b0, m_rdv = 1'b0;
  logic [31:0]   m_rdata = '0;
  logic          tmo;

  always #5 clk = ~clk;

  av_pipeline_stage #(.DW(DW), .AW(AW), .MAX_PENDING(MAXP), .TIMEOUT_CYC(TMO)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .s_av_address_i(s_addr), .s_av_byteenable_i(s_be), .s_av_read_i(s_rd),
    .s_av_write_i(s_wr), .s_av_writedata_i(s_wdata), .s_av_burstcount_i(s_burst),
    .s_av_waitrequest_o(s_wait), .s_av_readdata_o(s_rdata), .s_av_readdatavalid_o(s_rdv),
    .m_av_address_o(m_addr), .m_av_byteenable_o(m_be), .m_av_read_o(m_rd),
    .m_av_write_o(m_wr), .m_av_writedata_o(m_wdata), .m_av_burstcount_o(m_burst),
    .m_av_waitrequest_i(m_wait), .m_av_readdata_i(m_rdata),
    .m_av_readdatavalid_i(m_rdv), .timeout_o(tmo)
  );

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [3:0]    be;
    logic [31:0]   wdata;
  } cmd_t;
  typedef struct {
    logic [31:0] data;
    int          due;
  } sresp_t;

  cmd_t        exp_cmd[$];
  logic [31:0] exp_rsp[$];
  logic [31:0] exp_mem[16];
  logic [31:0] slv_mem[16];
  sresp_t      slv_q[$];
  int          us_log[$], ds_log[$], rsp_log[$];
  int          cyc = 0, last_due = 0, slave_lat = 2, ntx = 0;
  int          total = 0, bad = 0;
  bit          slave_hold = 1'b0, rnd_mode = 1'b0, us_acc = 1'b0;
`ifdef AV_PIPE_TIMEOUT_EN
  bit          tmo_armed = 1'b0;
`endif

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  function automatic void clear_logs();
    us_log.delete(); ds_log.delete(); rsp_log.delete();
  endfunction

  // One clock: score the handshakes of the coming edge at the negedge, then
  // advance and let the slave present its next response.
  task automatic cycle();
    cmd_t   c;
    sresp_t r;
    logic [31:0] e;
    bit     ds_acc;
    @(negedge clk);
    us_acc = 1'b0;
    if (rst_n) begin
      if (exp_rsp.size() == MAXP) chk("wait_at_max", s_wait, 1'b1);
      chk("rd_wr_excl", m_rd & m_wr, 1'b0);
`ifdef AV_PIPE_TIMEOUT_EN
      chk("tmo_flag", tmo, s_rdv & tmo_armed);
`else
      chk("tmo_zero", tmo, 1'b0);
`endif
      if (s_rdv) begin
        rsp_log.push_back(cyc);
        if (exp_rsp.size() == 0) chk("rsp_unexpected", s_rdv, 1'b0);
        else begin
          e = exp_rsp.pop_front();
          chk("rsp_data", s_rdata, e);
        end
      end
      ds_acc = (m_rd | m_wr) & ~m_wait;
      if (ds_acc) begin
        ds_log.push_back(cyc);
        if (exp_cmd.size() == 0) chk("ds_unexpected", ds_acc, 1'b0);
        else begin
          c = exp_cmd.pop_front();
          chk("ds_we", m_wr, c.we);
          chk("ds_addr", m_addr, c.addr);
          chk("ds_be", m_be, c.be);
          if (c.we) chk("ds_wdata", m_wdata, c.wdata);
        end
        if (m_wr) slv_mem[m_addr[5:2]] = merge(slv_mem[m_addr[5:2]], m_wdata, m_be);
        else begin
          r.data   = slv_mem[m_addr[5:2]];
          r.due    = (cyc + slave_lat > last_due) ? cyc + slave_lat : last_due + 1;
          last_due = r.due;
          slv_q.push_back(r);
        end
      end
      us_acc = (s_rd | s_wr) & ~s_wait;
      if (us_acc) begin
        c.we = s_wr; c.addr = s_addr; c.be = s_be; c.wdata = s_wdata;
        exp_cmd.push_back(c);
        us_log.push_back(cyc);
        if (s_wr) exp_mem[s_addr[5:2]] = merge(exp_mem[s_addr[5:2]], s_wdata, s_be);
        else exp_rsp.push_back(exp_mem[s_addr[5:2]]);
        $display("txn %0d: %s addr=%h be=%h wdata=%h cycle=%0d", ntx, s_wr ? "WR" : "RD",
                 s_addr, s_be, s_wdata, cyc);
        ntx++;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rnd_mode) begin
      m_wait    = ($urandom_range(0, 3) == 0);
      slave_lat = $urandom_range(1, 6);
    end
    if (!slave_hold && slv_q.size() != 0 && slv_q[0].due <= cyc) begin
      r = slv_q.pop_front();
      m_rdv = 1'b1; m_rdata = r.data;
    end else begin
      m_rdv = 1'b0; m_rdata = $urandom;
    end
  endtask

  task automatic issue(input bit we, input logic [AW-1:0] a, input logic [3:0] be,
                       input logic [31:0] d);
    int n = 0;
    s_rd = ~we; s_wr = we; s_addr = a; s_be = be; s_wdata = d;
    do begin
      cycle();
      n++;
    end while (!us_acc && n < 200);
    chk("issue_accept", us_acc, 1'b1);
  endtask

  task automatic idle(input int n);
    s_rd = 1'b0; s_wr = 1'b0;
    repeat (n) cycle();
  endtask

  task automatic drain();
    int n = 0;
    s_rd = 1'b0; s_wr = 1'b0; m_wait = 1'b0; rnd_mode = 1'b0;
    while ((exp_rsp.size() != 0 || exp_cmd.size() != 0) && n < 500) begin
      cycle();
      n++;
    end
    chk("drain_rsp", exp_rsp.size(), 0);
    chk("drain_cmd", exp_cmd.size(), 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ctl"}, {s_wait, s_rdv, m_rd, m_wr, tmo}, 5'b0);
    chk({tag, "_addr"}, m_addr, 0);
    chk({tag, "_be"}, m_be, 0);
    chk({tag, "_wdata"}, m_wdata, 0);
    chk({tag, "_rdata"}, s_rdata, 0);
    chk({tag, "_burst"}, m_burst, 1);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      slv_mem[i] = $urandom;
      exp_mem[i] = slv_mem[i];
    end
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    idle(2);

    // Four back-to-back writes with no downstream stall.
    clear_logs();
    for (int i = 0; i < 4; i++) issue(1'b1, AW'(4 * i), 4'hF, $urandom);
    idle(3);
    chk("t1_us_count", us_log.size(), 4);
    chk("t1_ds_count", ds_log.size(), 4);
    if (us_log.size() == 4 && ds_log.size() == 4)
      for (int i = 0; i < 4; i++) begin
        chk("t1_b2b", us_log[i], us_log[0] + i);
        chk("t1_latency", ds_log[i], us_log[i] + 1);
      end

    // Downstream stall: second command lands in SKID and stalls upstream.
    m_wait = 1'b1;
    issue(1'b1, 32'h40, 4'h3, $urandom);
    issue(1'b0, 32'h100, 4'hF, 32'h0);
    chk("t2_skid_wait", s_wait, 1'b1);
    idle(2);
    chk("t2_skid_hold", s_wait, 1'b1);
    drain();

    // Outstanding-read limit with a slow slave.
    slave_lat = 10;
    clear_logs();
    for (int i = 0; i < 6; i++) issue(1'b0, AW'(4 * $urandom_range(0, 15)), 4'hF, 32'h0);
    drain();
    chk("t3_rsp_count", rsp_log.size(), 6);
    if (us_log.size() == 6 && rsp_log.size() != 0) begin
      for (int i = 1; i < 4; i++) chk("t3_b2b", us_log[i], us_log[0] + i);
      chk("t3_stall_release", us_log[4], rsp_log[0] + 1);
    end

    // Asynchronous reset with reads outstanding and a write stalled in MAIN.
    slave_lat = 8;
    issue(1'b0, 32'h8, 4'hF, 32'h0);
    issue(1'b0, 32'hC, 4'hF, 32'h0);
    m_wait = 1'b1;
    issue(1'b1, 32'h10, 4'hF, $urandom);
    idle(1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("t4_async");
    exp_rsp.delete();
    exp_cmd.delete();
    m_wait = 1'b0;
    idle(2);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) exp_mem[i] = slv_mem[i];
    idle(12);
    chk("t4_late_delivered", slv_q.size(), 0);

`ifdef AV_PIPE_TIMEOUT_EN
    // Silent slave: synthetic response, then the late real one is discarded.
    slave_hold = 1'b1;
    clear_logs();
    issue(1'b0, 32'h14, 4'hF, 32'h0);
    exp_rsp[exp_rsp.size() - 1] = 32'hDEADBEEF;
    tmo_armed = 1'b1;
    for (int n = 0; n < 40 && rsp_log.size() == 0; n++) cycle();
    chk("t5_tmo_seen", rsp_log.size(), 1);
    if (rsp_log.size() != 0 && ds_log.size() != 0)
      chk("t5_tmo_window", (rsp_log[0] - ds_log[0] >= TMO) && (rsp_log[0] - ds_log[0] <= TMO + 2), 1'b1);
    tmo_armed = 1'b0;
    slave_hold = 1'b0;
    idle(4);
    chk("t5_late_flushed", slv_q.size(), 0);
`endif

    // Randomized traffic with random downstream stalls and latencies.
    rnd_mode = 1'b1;
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 1) == 1)
        issue(1'b1, AW'(4 * $urandom_range(0, 15)), 4'($urandom_range(1, 15)), $urandom);
      else
        issue(1'b0, AW'(4 * $urandom_range(0, 15)), 4'hF, 32'h0);
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
